// File: rtl/enc8to3_stream.sv
// enc8to3_stream: sequential 8-to-3 encoder.
// Accepts an 8-bit request vector on an input valid/ready handshake and then
// emits one 3-bit index per set bit, lowest index first, one per output
// handshake. The final code of each vector is flagged with 'last'. An all-zero
// vector yields a single beat with 'empty' set. 'el' is an active-low enable
// that freezes all state and masks both handshakes while high.
module enc8to3_stream (
    input  logic       clk,
    input  logic       rst,
    input  logic       el,
    input  logic [7:0] D,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [2:0] Y,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       last,
    output logic       empty
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_EMIT = 1'b1;

    logic [0:0] state_q, state_d;
    logic [7:0] pend_q, pend_d;
    logic       zero_flag_q, zero_flag_d;

    logic [2:0] low_idx;
    logic       at_most_one;
    logic       in_fire;
    logic       out_fire;

    // Priority search for the lowest set bit of the pending vector.
    always_comb begin
        low_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (pend_q[i]) begin
                low_idx = 3'(i);
            end
        end
    end

    // Clearing the lowest set bit leaves zero exactly when at most one bit is set.
    assign at_most_one = ((pend_q & (pend_q - 8'd1)) == 8'd0);

    // Handshake qualifiers and output codes, all derived from registered state.
    assign in_ready  = (state_q == ST_IDLE) & ~el;
    assign out_valid = (state_q == ST_EMIT) & ~el;
    assign Y         = zero_flag_q ? 3'd0 : low_idx;
    assign last      = (state_q == ST_EMIT) & (at_most_one | zero_flag_q);
    assign empty     = zero_flag_q;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    // Next-state logic: load on input handshake, retire one code per output handshake.
    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        zero_flag_d = zero_flag_q;
        case (state_q)
            ST_IDLE: begin
                if (in_fire) begin
                    pend_d      = D;
                    zero_flag_d = (D == 8'd0);
                    state_d     = ST_EMIT;
                end
            end
            default: begin
                if (out_fire) begin
                    if (last) begin
                        pend_d      = 8'd0;
                        zero_flag_d = 1'b0;
                        state_d     = ST_IDLE;
                    end else begin
                        pend_d[low_idx] = 1'b0;
                    end
                end
            end
        endcase
    end

    // State registers; reset discards any vector still being emitted.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            pend_q      <= 8'd0;
            zero_flag_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            zero_flag_q <= zero_flag_d;
        end
    end

endmodule

// File: tb/tb_enc8to3_stream.sv
// Testbench for enc8to3_stream: directed scenarios followed by randomized
// vectors with random backpressure and enable stalls, checked against a
// queue-based reference model of the expected code stream.
module tb_enc8to3_stream;

    logic       clk = 1'b0;
    logic       rst;
    logic       el;
    logic [7:0] D;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] Y;
    logic       out_valid;
    logic       out_ready;
    logic       last;
    logic       empty;

    int checks = 0;
    int errors = 0;

    // Reference model output: one entry per expected beat.
    int exp_y[$];
    int exp_last[$];
    int exp_empty[$];

    enc8to3_stream dut (
        .clk       (clk),
        .rst       (rst),
        .el        (el),
        .D         (D),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Y         (Y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .last      (last),
        .empty     (empty)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected beats of a vector: the indices of its set bits in ascending
    // order, the last one flagged; a zero vector is one empty beat at index 0.
    task automatic build_model(input logic [7:0] v);
        exp_y.delete();
        exp_last.delete();
        exp_empty.delete();
        if (v == 8'd0) begin
            exp_y.push_back(0);
            exp_last.push_back(1);
            exp_empty.push_back(1);
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (v[i]) begin
                    exp_y.push_back(i);
                    exp_last.push_back(0);
                    exp_empty.push_back(0);
                end
            end
            exp_last[exp_last.size() - 1] = 1;
        end
    endtask

    // Present a vector for one cycle; returns at the negedge after the handshake.
    task automatic accept(input logic [7:0] v);
        @(negedge clk);
        el = 1'b0;
        out_ready = 1'b0;
        #1;
        check("in_ready_before_accept", 8'(in_ready), 8'd1);
        in_valid = 1'b1;
        D = v;
        @(negedge clk);
        in_valid = 1'b0;
        D = 8'($urandom);
    endtask

    // Check one beat with el=0 and present the given out_ready for the coming edge.
    task automatic beat(input string tag, input int y, input int lst, input int emp, input logic rdy);
        el = 1'b0;
        out_ready = rdy;
        #1;
        check({tag, "_valid"}, 8'(out_valid), 8'd1);
        check({tag, "_y"}, 8'(Y), 8'(y));
        check({tag, "_last"}, 8'(last), 8'(lst));
        check({tag, "_empty"}, 8'(empty), 8'(emp));
        @(negedge clk);
    endtask

    // Full transaction against the model with random backpressure and stalls.
    task automatic play(input logic [7:0] v, input int rdy_pct, input int el_pct);
        int b;
        int guard;
        logic rdy;
        logic stall;
        build_model(v);
        accept(v);
        b = 0;
        guard = 0;
        while (b < exp_y.size() && guard < 300) begin
            guard++;
            stall = ($urandom_range(99) < el_pct);
            rdy = ($urandom_range(99) < rdy_pct);
            el = stall;
            out_ready = rdy;
            #1;
            if (stall) begin
                check("stall_out_valid", 8'(out_valid), 8'd0);
                check("stall_in_ready", 8'(in_ready), 8'd0);
            end else begin
                check("beat_valid", 8'(out_valid), 8'd1);
                check("beat_y", 8'(Y), 8'(exp_y[b]));
                check("beat_last", 8'(last), 8'(exp_last[b]));
                check("beat_empty", 8'(empty), 8'(exp_empty[b]));
                check("beat_in_ready", 8'(in_ready), 8'd0);
                if (rdy) b++;
            end
            @(negedge clk);
        end
        check("beat_budget", 8'(guard < 300), 8'd1);
        el = 1'b0;
        out_ready = 1'b0;
        #1;
        check("done_in_ready", 8'(in_ready), 8'd1);
        check("done_out_valid", 8'(out_valid), 8'd0);
        $display("vector %02h: %0d beats in %0d cycles", v, exp_y.size(), guard);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        el = 1'b0;
        D = 8'd0;
        in_valid = 1'b0;
        out_ready = 1'b0;

        // Reset for two cycles, then release.
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        check("rst_out_valid", 8'(out_valid), 8'd0);
        check("rst_in_ready", 8'(in_ready), 8'd1);
        check("rst_y", 8'(Y), 8'd0);
        check("rst_last", 8'(last), 8'd0);
        check("rst_empty", 8'(empty), 8'd0);
        $display("reset checked");

        // Sparse vector at full rate.
        play(8'b1001_0110, 100, 0);
        // Zero vector then all-ones.
        play(8'h00, 100, 0);
        play(8'hFF, 100, 0);

        // Backpressure: hold the first code for three cycles.
        accept(8'h82);
        for (int i = 0; i < 3; i++) beat("bp_hold", 1, 0, 0, 1'b0);
        beat("bp_first", 1, 0, 0, 1'b1);
        beat("bp_second", 7, 1, 0, 1'b1);
        #1;
        check("bp_done_in_ready", 8'(in_ready), 8'd1);
        $display("backpressure vector 82 checked");

        // Enable stall after the second code of 0F.
        accept(8'h0F);
        beat("en_c0", 0, 0, 0, 1'b1);
        beat("en_c1", 1, 0, 0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            el = 1'b1;
            out_ready = 1'b1;
            in_valid = 1'b1;
            #1;
            check("en_stall_out_valid", 8'(out_valid), 8'd0);
            check("en_stall_in_ready", 8'(in_ready), 8'd0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        beat("en_c2", 2, 0, 0, 1'b1);
        beat("en_c3", 3, 1, 0, 1'b1);
        #1;
        check("en_done_in_ready", 8'(in_ready), 8'd1);
        $display("enable stall vector 0F checked");

        // Reset in the middle of F0 after code 4 is accepted.
        accept(8'hF0);
        beat("mr_c4", 4, 0, 0, 1'b1);
        rst = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mr_out_valid", 8'(out_valid), 8'd0);
        check("mr_in_ready", 8'(in_ready), 8'd1);
        $display("mid-stream reset checked");
        play(8'h01, 100, 0);

        // Randomized vectors with random backpressure and enable stalls.
        for (int n = 0; n < 40; n++) begin
            play(8'($urandom), 70, 20);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
